mem_dump_streamer: RTL and testbench
====================================

MEM_DUMP_STREAMER -- requirements
Module: mem_dump_streamer

Interface
REQ-001 Parameter: COUNT_W, 16, width of the word-count input and the internal word index.
REQ-002 Port: clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 Port: start  in  1  request a dump; sampled only in IDLE.
REQ-005 Port: abort  in  1  cancel an in-progress dump.
REQ-006 Port: base_addr  in  32  byte address of the first word; latched on accepted start.
REQ-007 Port: word_count  in  COUNT_W  number of 32-bit words to dump; latched on accepted start.
REQ-008 Port: busy  out  1  high in READ, SEND and DONE.
REQ-009 Port: done  out  1  one-cycle pulse on normal completion.
REQ-010 Port: io_dmem_address  out  32  data-memory byte address.
REQ-011 Port: io_dmem_writedata  out  32  constant 0.
REQ-012 Port: io_dmem_memread  out  1  read strobe.
REQ-013 Port: io_dmem_memwrite  out  1  constant 0.
REQ-014 Port: io_dmem_maskmode  out  2  constant 2 (word access).
REQ-015 Port: io_dmem_sext  out  1  constant 0.
REQ-016 Port: io_dmem_readdata  in  32  combinational read data, valid in the same cycle as memread.
REQ-017 Port: out_valid  out  1  byte-stream valid.
REQ-018 Port: out_ready  in  1  byte-stream ready from the sink.
REQ-019 Port: out_data  out  8  stream byte.
REQ-020 Port: out_last  out  1  marks the final byte of the dump.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, READ, SEND and DONE.
REQ-022 In IDLE with start=1, the block SHALL latch base_addr and word_count, clear the word index idx and byte index k, and go to READ if word_count is nonzero, otherwise to DONE.
REQ-023 In READ, for exactly one cycle, the block SHALL drive io_dmem_memread=1 and io_dmem_address=base+4*idx (mod 2^32), capture io_dmem_readdata into a 32-bit buffer, and go to SEND.
REQ-024 io_dmem_memread SHALL be 0 in every state other than READ; io_dmem_address SHALL hold its last value outside READ.
REQ-025 In SEND, the block SHALL drive out_valid=1 and out_data=buffer[8k+7:8k], so bytes are emitted little-endian (k=0 first).
REQ-026 A byte SHALL transfer only on a cycle with out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 On a transfer with k<3, the block SHALL increment k; on a transfer with k=3, it SHALL clear k, increment idx, and go to DONE if idx was count-1, otherwise to READ.
REQ-028 out_last SHALL be 1 only while in SEND with k=3 and idx=count-1.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 With word_count=0, the block SHALL pass through DONE only, emitting no memread and no stream bytes.
REQ-031 start SHALL be ignored when the FSM is not in IDLE.
REQ-032 abort=1 in READ or SEND SHALL force IDLE on the next edge, with no done pulse, out_valid=0 from that edge, and any partially sent word discarded.
REQ-033 abort SHALL have priority over a same-cycle out_ready transfer.
REQ-034 abort in IDLE or DONE SHALL have no effect (DONE still pulses done).
REQ-035 Address arithmetic SHALL wrap modulo 2^32, so base 0xFFFFFFFC followed by idx 1 yields address 0x00000000.
REQ-036 Total dump latency SHALL be 5*count + 1 cycles, counted from the accepted start to the done pulse, with out_ready held at 1.

Reset
REQ-037 While reset=0, the block SHALL immediately (asynchronously) enter IDLE and clear idx, k, the buffer and io_dmem_address.
REQ-038 While reset=0, outputs SHALL be: busy=0, done=0, out_valid=0, out_last=0, out_data=0, io_dmem_memread=0.
REQ-039 Reset asserted mid-dump SHALL abandon the dump with no done pulse.
REQ-040 After reset is released, the block SHALL accept start on the first rising edge.

Verification
REQ-041 Basic dump: base 0x100, count 2, mem[0x100]=0x44332211, mem[0x104]=0x88776655, ready=1 -> bytes 11 22 33 44 55 66 77 88, out_last only on 0x88, done 11 cycles after start.
REQ-042 Backpressure: same setup, out_ready toggled 1/0 -> identical byte order, out_data stable while stalled, exactly 2 memread pulses (0x100, 0x104).
REQ-043 Zero count: start with word_count 0 -> done next cycle, no memread, no out_valid.
REQ-044 Wrap: base 0xFFFFFFFC, count 2 -> memread addresses 0xFFFFFFFC then 0x00000000.
REQ-045 Abort/restart: abort at the 2nd byte of word 0 -> IDLE, no done; a new start reads from the newly latched base_addr.
REQ-046 Mid-dump reset: reset=0 during SEND -> all outputs zero immediately; after release, a new dump runs correctly.

Source files
------------

// File: rtl/mem_dump_streamer.sv
// Reads word_count 32-bit words from data memory starting at base_addr and
// streams them out as little-endian bytes over a valid/ready interface.
module mem_dump_streamer #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic [31:0]        io_dmem_address,
    output logic [31:0]        io_dmem_writedata,
    output logic               io_dmem_memread,
    output logic               io_dmem_memwrite,
    output logic [1:0]         io_dmem_maskmode,
    output logic               io_dmem_sext,
    input  logic [31:0]        io_dmem_readdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_base;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_idx;
    logic [1:0]         r_k;
    logic [31:0]        r_buf;
    logic [31:0]        r_addr;

    logic [31:0]        w_rd_addr;
    logic               w_last_word;
    logic [7:0]         w_byte;

    // Byte address of the current word; 32-bit add wraps naturally.
    assign w_rd_addr   = r_base + (32'(r_idx) << 2);
    assign w_last_word = (r_idx == (r_count - COUNT_W'(1)));
    assign w_byte      = r_buf[{r_k, 3'b000} +: 8];

    assign io_dmem_writedata = '0;
    assign io_dmem_memwrite  = 1'b0;
    assign io_dmem_maskmode  = 2'd2;
    assign io_dmem_sext      = 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                w_next = abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (out_ready && (r_k == 2'd3)) begin
                    w_next = w_last_word ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outside READ the address bus replays the last issued read address.
    always_comb begin
        busy            = (r_state != S_IDLE);
        done            = (r_state == S_DONE);
        io_dmem_memread = (r_state == S_READ);
        io_dmem_address = (r_state == S_READ) ? w_rd_addr : r_addr;
        out_valid       = (r_state == S_SEND);
        out_data        = '0;
        out_last        = 1'b0;
        if (r_state == S_SEND) begin
            out_data = w_byte;
            out_last = (r_k == 2'd3) && w_last_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_k     <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_count <= word_count;
                        r_idx   <= '0;
                        r_k     <= '0;
                    end
                end
                S_READ: begin
                    r_buf  <= io_dmem_readdata;
                    r_addr <= w_rd_addr;
                end
                S_SEND: begin
                    if (abort) begin
                        r_k <= '0;
                    end else if (out_ready) begin
                        if (r_k == 2'd3) begin
                            r_k   <= '0;
                            r_idx <= r_idx + COUNT_W'(1);
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed-plus-random bench for mem_dump_streamer; expected addresses and
// byte stream are derived from a reference memory function and queues.
module tb_mem_dump_streamer;

    localparam int unsigned COUNT_W = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [31:0]        base_addr;
    logic [COUNT_W-1:0] word_count;
    logic               busy;
    logic               done;
    logic [31:0]        io_dmem_address;
    logic [31:0]        io_dmem_writedata;
    logic               io_dmem_memread;
    logic               io_dmem_memwrite;
    logic [1:0]         io_dmem_maskmode;
    logic               io_dmem_sext;
    logic [31:0]        io_dmem_readdata;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_last;

    logic [31:0]        seed;
    int                 vectors = 0;
    int                 errors  = 0;

    mem_dump_streamer #(.COUNT_W(COUNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .io_dmem_address   (io_dmem_address),
        .io_dmem_writedata (io_dmem_writedata),
        .io_dmem_memread   (io_dmem_memread),
        .io_dmem_memwrite  (io_dmem_memwrite),
        .io_dmem_maskmode  (io_dmem_maskmode),
        .io_dmem_sext      (io_dmem_sext),
        .io_dmem_readdata  (io_dmem_readdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last)
    );

    always #5 clock = ~clock;

    // Reference memory: two fixed words for the basic dump, hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        if (a == 32'h0000_0100) return 32'h4433_2211;
        if (a == 32'h0000_0104) return 32'h8877_6655;
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    assign io_dmem_readdata = mem_word(io_dmem_address, seed);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_busy"},  busy,            32'd0);
        check({tag, "_done"},  done,            32'd0);
        check({tag, "_valid"}, out_valid,       32'd0);
        check({tag, "_last"},  out_last,        32'd0);
        check({tag, "_data"},  out_data,        32'd0);
        check({tag, "_rd"},    io_dmem_memread, 32'd0);
    endtask

    // mode: 0 ready held high, 1 ready toggles, 2 ready random.
    // act:  0 none, 1 abort once act_at bytes are sent, 2 reset at that point.
    // Called just after a negedge with the DUT in IDLE; returns likewise.
    task automatic run_dump(input logic [31:0] base, input int cnt, input int mode,
                            input int act, input int act_at);
        logic [31:0] exp_addr[$];
        logic [7:0]  exp_bytes[$];
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  stall_data;
        bit          stall    = 1'b0;
        bit          aborted  = 1'b0;
        bit          finished = 1'b0;
        int          sent     = 0;

        for (int i = 0; i < cnt; i++) begin
            a = base + 32'(4 * i);
            exp_addr.push_back(a);
            w = mem_word(a, seed);
            for (int j = 0; j < 4; j++) begin
                exp_bytes.push_back(8'(w >> (8 * j)));
            end
        end

        base_addr  = base;
        word_count = COUNT_W'(cnt);
        start      = 1'b1;
        abort      = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("idle_busy", busy, 32'd0);

        for (int cyc = 1; cyc <= 10 * cnt + 20 && !finished; cyc++) begin
            @(negedge clock);
            start      = aborted ? 1'b0 : 1'($urandom_range(0, 1));
            base_addr  = $urandom;
            word_count = COUNT_W'($urandom);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            abort = 1'b0;
            if (act == 1 && !aborted && out_valid && sent == act_at) abort = 1'b1;

            if (act == 2 && out_valid && sent == act_at) begin
                start = 1'b0;
                #2 reset = 1'b0;
                #1;
                check_quiet_outputs("rst_mid");
                check("rst_mid_addr", io_dmem_address, 32'd0);
                @(negedge clock);
                check_quiet_outputs("rst_hold");
                reset = 1'b1;
                return;
            end

            #1;
            if (aborted) begin
                check_quiet_outputs("abort_idle");
                start = 1'b0;
                return;
            end

            check("busy", busy, 32'd1);
            if (stall) begin
                check("stall_valid", out_valid, 32'd1);
                check("stall_data",  out_data,  stall_data);
            end
            if (io_dmem_memread) begin
                if (exp_addr.size() == 0) check("extra_read", 32'd1, 32'd0);
                else check("rd_addr", io_dmem_address, exp_addr.pop_front());
            end
            check("last", out_last, out_valid && exp_bytes.size() == 1);
            if (out_valid) begin
                if (exp_bytes.size() == 0) check("extra_byte", 32'd1, 32'd0);
                else check("byte", out_data, exp_bytes[0]);
                if (out_ready && !abort && exp_bytes.size() != 0) begin
                    void'(exp_bytes.pop_front());
                    sent++;
                end
            end
            stall      = out_valid && !out_ready && !abort;
            stall_data = out_data;
            if (abort) aborted = 1'b1;

            if (done) begin
                if (mode == 0) check("latency", cyc, 5 * cnt + 1);
                check("bytes_left", exp_bytes.size(), 32'd0);
                check("reads_left", exp_addr.size(),  32'd0);
                check("done_valid", out_valid, 32'd0);
                finished = 1'b1;
            end
        end

        if (!finished) begin
            check("timeout", 32'd0, 32'd1);
            abort = 1'b1;
            @(negedge clock);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        #1;
        check("post_done", done, 32'd0);
        check("post_busy", busy, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seed       = $urandom;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        base_addr  = '0;
        word_count = '0;
        #1;
        check_quiet_outputs("reset");
        check("reset_addr", io_dmem_address,   32'd0);
        check("wdata",      io_dmem_writedata, 32'd0);
        check("memwrite",   io_dmem_memwrite,  32'd0);
        check("maskmode",   io_dmem_maskmode,  32'd2);
        check("sext",       io_dmem_sext,      32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_dump(32'h0000_0100, 2, 0, 0, 0);
        run_dump(32'h0000_0100, 2, 1, 0, 0);
        run_dump(32'h0000_0100, 0, 0, 0, 0);
        run_dump(32'hFFFF_FFFC, 2, 2, 0, 0);
        run_dump(32'h0000_0100, 2, 0, 1, 1);
        run_dump($urandom & 32'hFFFF_FFFC, 3, 2, 0, 0);
        run_dump(32'h0000_0100, 2, 2, 1, 6);
        run_dump(32'h0000_0100, 2, 0, 2, 2);
        run_dump(32'h0000_0100, 2, 0, 0, 0);
        run_dump($urandom, 3, 1, 2, 9);
        run_dump($urandom, 1, 0, 0, 0);
        for (int t = 0; t < 8; t++) begin
            run_dump($urandom, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
